onehot_sel_decoder: RTL
=======================

Name: onehot_sel_decoder

Overview:
Converts a stream of encoded branch indices back into one-hot branch-select vectors: the inverse of the priority/unique-if encoder used across our conditional blocks. Each accepted index yields exactly one select vector, or an all-zero vector flagged as no-match when the index is out of range. A 2-entry output buffer with valid/ready handshakes on both sides decouples producer and consumer. Saturating counters record total decodes and no-match events for debug readout.

Parameters:
N, 3, number of branches (width of one-hot output); legal range 2..16
IDX_W, 2, index width; must satisfy 2**IDX_W >= N
CNT_W, 8, width of the statistics counters

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
in_valid  input  1  index present on in_idx
in_ready  output  1  block can accept an index this cycle
in_idx  input  IDX_W  encoded branch index
out_valid  output  1  out_sel/out_nomatch valid
out_ready  input  1  consumer accepts output this cycle
out_sel  output  N  one-hot select; all zeros on no-match
out_nomatch  output  1  in_idx was >= N
dec_cnt  output  CNT_W  saturating count of accepted indices
nomatch_cnt  output  CNT_W  saturating count of accepted out-of-range indices
clr_cnt  input  1  synchronous clear of both counters

Behaviour:
- Reset (rst=1 at clk edge): buffer emptied; out_valid=0, out_sel=0, out_nomatch=0, dec_cnt=0, nomatch_cnt=0; in_ready=1 in the first cycle after reset. Reset mid-transfer discards buffered entries; no partial output.
- Accept = in_valid & in_ready. Emit = out_valid & out_ready.
- Decode: idx < N -> out_sel bit idx set, all others 0, out_nomatch=0. idx >= N -> out_sel=0, out_nomatch=1. Never more than one bit set.
- Latency: accepted at edge k -> out_valid=1 from cycle k+1, when the buffer was empty.
- Buffer: 2-entry FIFO of {sel,nomatch}. in_ready = (count < 2); registered, no combinational out_ready->in_ready path. State EMPTY/ONE/FULL:
  EMPTY: accept -> ONE.
  ONE: accept & !emit -> FULL; emit & !accept -> EMPTY; both -> ONE, new entry queued behind head.
  FULL: emit -> ONE; in_ready=0 so no accept.
- Order is strict FIFO. Output stable while out_valid & !out_ready: out_sel and out_nomatch must not change.
- Counters: dec_cnt +1 per accept; nomatch_cnt +1 per accept with idx>=N. Both saturate at 2**CNT_W-1, no wrap. clr_cnt has priority over a same-cycle increment (result 0). rst overrides everything.
- out_sel/out_nomatch are don't-care-free: drive 0 when out_valid=0.
- Assertions: $onehot0(out_sel); out_nomatch -> out_sel==0; out_valid & !out_nomatch -> $onehot(out_sel).

Decomposition:
- Package onehot_sel_pkg: parameter defaults, typedef struct packed {logic [N-1:0] sel; logic nomatch;} sel_entry_t, typedef enum {EMPTY,ONE,FULL} buf_state_t.
- Sub-module sel_skid_fifo2: generic 2-entry valid/ready buffer of sel_entry_t; top holds the decode logic and counters.

Test Plan:
- Reset then in_idx=0,1,2 back-to-back, out_ready=1 -> out_sel 3'b001,3'b010,3'b100 on cycles 1,2,3; dec_cnt=3, nomatch_cnt=0.
- in_idx=3 (N=3) -> out_sel=3'b000, out_nomatch=1, nomatch_cnt=1.
- out_ready=0, push idx 2,0,1 -> first two accepted, in_ready=0 on third; out_sel holds 3'b100; release out_ready -> 3'b100, 3'b001, then 3'b010 in order, none lost.
- Push 260 valid indices with CNT_W=8 -> dec_cnt=255 saturates; clr_cnt together with an accept -> dec_cnt=0.
- Assert rst with buffer FULL -> next cycle out_valid=0, in_ready=1, counters 0; subsequent idx=1 -> 3'b010.
- Random in_valid/out_ready for 10k cycles against a scoreboard -> output sequence matches decoded input, onehot0 assertion never fires.

Source files
------------

// File: rtl/onehot_sel_pkg.sv
// Shared definitions for the one-hot select decoder.
// Holds parameter defaults, the output buffer state encoding and the default
// buffer entry layout ({sel, nomatch}) for the default branch count.
package onehot_sel_pkg;

    localparam int N_DEF     = 3;
    localparam int IDX_W_DEF = 2;
    localparam int CNT_W_DEF = 8;

    // Occupancy of the 2-entry output buffer.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } buf_state_t;

    // Entry layout at the default branch count. The top re-declares the same
    // layout locally so that it follows its own N parameter.
    typedef struct packed {
        logic [N_DEF-1:0] sel;
        logic             nomatch;
    } sel_entry_t;

endpackage

// File: rtl/sel_skid_fifo2.sv
// Purpose: generic 2-entry valid/ready buffer; head entry drives the output.
// Latency: push at edge k is visible on pop side from cycle k+1 when empty.
// Backpressure: push_ready_o is registered (state != FULL); no pop->push comb path.
// Ports: clk/rst (sync, active-high); push_valid_i/push_ready_o/push_data_i;
//        pop_valid_o/pop_ready_i/pop_data_o (zero while pop_valid_o is low).
module sel_skid_fifo2
    import onehot_sel_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_valid_i,
    output logic         push_ready_o,
    input  logic [W-1:0] push_data_i,
    output logic         pop_valid_o,
    input  logic         pop_ready_i,
    output logic [W-1:0] pop_data_o
);

    buf_state_t   state_q;
    logic [W-1:0] head_q;
    logic [W-1:0] tail_q;
    logic         vld_q;
    logic         rdy_q;
    logic         push;
    logic         pop;

    assign push = push_valid_i & rdy_q;
    assign pop  = vld_q & pop_ready_i;

    // Head and tail are cleared whenever they are vacated, so the output data
    // is already zero whenever pop_valid_o is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
            vld_q   <= 1'b0;
            rdy_q   <= 1'b1;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (push) begin
                        head_q  <= push_data_i;
                        vld_q   <= 1'b1;
                        state_q <= ONE;
                    end
                end
                ONE: begin
                    if (push && !pop) begin
                        tail_q  <= push_data_i;
                        rdy_q   <= 1'b0;
                        state_q <= FULL;
                    end else if (pop && !push) begin
                        head_q  <= '0;
                        vld_q   <= 1'b0;
                        state_q <= EMPTY;
                    end else if (pop && push) begin
                        // Head leaves while the new entry takes its place.
                        head_q  <= push_data_i;
                    end
                end
                FULL: begin
                    // rdy_q is low here, so no push can coincide.
                    if (pop) begin
                        head_q  <= tail_q;
                        tail_q  <= '0;
                        rdy_q   <= 1'b1;
                        state_q <= ONE;
                    end
                end
                default: begin
                    state_q <= EMPTY;
                    head_q  <= '0;
                    tail_q  <= '0;
                    vld_q   <= 1'b0;
                    rdy_q   <= 1'b1;
                end
            endcase
        end
    end

    assign push_ready_o = rdy_q;
    assign pop_valid_o  = vld_q;
    assign pop_data_o   = head_q;

endmodule

// File: rtl/onehot_sel_decoder.sv
// Purpose: decode branch indices into one-hot selects (no-match flag when idx >= N).
// Latency: one cycle from accept to out_valid when the buffer is empty.
// Backpressure: 2-entry buffer; in_ready is registered and drops only when full.
// Ports: clk/rst (sync, active-high); in_valid/in_ready/in_idx input handshake;
//        out_valid/out_ready/out_sel/out_nomatch output handshake;
//        dec_cnt/nomatch_cnt saturating debug counters, clr_cnt clears both.
module onehot_sel_decoder
    import onehot_sel_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int IDX_W = IDX_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IDX_W-1:0] in_idx,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_sel,
    output logic             out_nomatch,
    output logic [CNT_W-1:0] dec_cnt,
    output logic [CNT_W-1:0] nomatch_cnt,
    input  logic             clr_cnt
);

    typedef struct packed {
        logic [N-1:0] sel;
        logic         nomatch;
    } entry_t;

    localparam int             ENT_W   = $bits(entry_t);
    localparam logic [31:0]    N_U     = 32'(N);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    entry_t           dec_ent;
    entry_t           out_ent;
    logic [31:0]      idx_ext;
    logic             accept;
    logic [CNT_W-1:0] dec_cnt_q;
    logic [CNT_W-1:0] dec_cnt_d;
    logic [CNT_W-1:0] nomatch_cnt_q;
    logic [CNT_W-1:0] nomatch_cnt_d;

    assign idx_ext = 32'(in_idx);

    // Decode: at most one bit set; out-of-range indices yield all-zero + flag.
    always_comb begin
        dec_ent         = '0;
        dec_ent.nomatch = (idx_ext >= N_U);
        for (int unsigned i = 0; i < N; i++) begin
            if (idx_ext == i) begin
                dec_ent.sel[i] = 1'b1;
            end
        end
    end

    sel_skid_fifo2 #(
        .W (ENT_W)
    ) u_buf (
        .clk          (clk),
        .rst          (rst),
        .push_valid_i (in_valid),
        .push_ready_o (in_ready),
        .push_data_i  (dec_ent),
        .pop_valid_o  (out_valid),
        .pop_ready_i  (out_ready),
        .pop_data_o   (out_ent)
    );

    assign accept      = in_valid & in_ready;
    assign out_sel     = out_ent.sel;
    assign out_nomatch = out_ent.nomatch;

    // Saturating counters; a clear wins over a same-cycle increment.
    always_comb begin
        dec_cnt_d     = dec_cnt_q;
        nomatch_cnt_d = nomatch_cnt_q;
        if (clr_cnt) begin
            dec_cnt_d     = '0;
            nomatch_cnt_d = '0;
        end else if (accept) begin
            if (dec_cnt_q != CNT_MAX) begin
                dec_cnt_d = dec_cnt_q + 1'b1;
            end
            if (dec_ent.nomatch && (nomatch_cnt_q != CNT_MAX)) begin
                nomatch_cnt_d = nomatch_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dec_cnt_q     <= '0;
            nomatch_cnt_q <= '0;
        end else begin
            dec_cnt_q     <= dec_cnt_d;
            nomatch_cnt_q <= nomatch_cnt_d;
        end
    end

    assign dec_cnt     = dec_cnt_q;
    assign nomatch_cnt = nomatch_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert ($onehot0(out_sel));
            assert (!out_nomatch || (out_sel == '0));
            assert (!(out_valid && !out_nomatch) || $onehot(out_sel));
        end
    end

endmodule
